// File: rtl/shifter_pkg.sv
// Shared constants and stage payload type for the pipelined left shifter.
// The payload struct is sized from the defaults, so the pipeline is built at those widths.
package shifter_pkg;

    localparam int unsigned WIDTH_DEFAULT = 16;
    localparam int unsigned SHW_DEFAULT   = 4;

    // Shift distance applied by each pipeline stage, first stage first.
    localparam int unsigned STAGE_SHIFT [SHW_DEFAULT] = '{8, 4, 2, 1};

    typedef struct packed {
        logic [WIDTH_DEFAULT-1:0] data;
        logic [SHW_DEFAULT-1:0]   ctrl;
        logic                     rot;
    } stage_payload_t;

endpackage

// File: rtl/mux2X1.sv
// Single-bit 2:1 multiplexer.
module mux2X1 (
    input  logic in0,
    input  logic in1,
    input  logic sel,
    output logic y
);

    assign y = sel ? in1 : in0;

endmodule

// File: rtl/shl_stage.sv
// Combinational conditional left shift or rotate by a fixed distance S.
module shl_stage #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned S     = 1
) (
    input  logic [WIDTH-1:0] data,
    input  logic             sel,
    input  logic             rot,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] shifted;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i < S) begin : g_fill
            // Vacated low bits take the wrapped-around top bits only when rotating.
            assign shifted[i] = rot & data[WIDTH-S+i];
        end else begin : g_move
            assign shifted[i] = data[i-S];
        end

        mux2X1 u_mux (
            .in0 (data[i]),
            .in1 (shifted[i]),
            .sel (sel),
            .y   (result[i])
        );
    end

endmodule

// File: rtl/barrel_shift_left_pipe.sv
// Four-stage pipelined 16-bit left shifter/rotator (8, 4, 2, 1) with valid/ready
// handshakes and a bubble-collapsing advance chain.
module barrel_shift_left_pipe
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT,
    parameter int unsigned SHW   = SHW_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_ctrl,
    input  logic             in_rot,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    if (WIDTH != WIDTH_DEFAULT || SHW != SHW_DEFAULT) begin : g_width_guard
        $error("barrel_shift_left_pipe: payload type is fixed at the package default widths");
    end

    stage_payload_t   src_p   [SHW];
    stage_payload_t   stage_d [SHW];
    stage_payload_t   stage_q [SHW];
    logic [WIDTH-1:0] shifted [SHW];
    logic [SHW-1:0]   valid_q;
    logic [SHW-1:0]   valid_in;
    logic [SHW-1:0]   adv;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        if (STAGE_SHIFT[k] != 2 ** (SHW - 1 - k)) begin : g_table_guard
            $error("barrel_shift_left_pipe: stage shift table does not match SHW");
        end

        if (k == 0) begin : g_head
            assign src_p[k] = '{data: in_data, ctrl: in_ctrl, rot: in_rot};
        end else begin : g_body
            assign src_p[k] = stage_q[k-1];
        end

        shl_stage #(
            .WIDTH (WIDTH),
            .S     (STAGE_SHIFT[k])
        ) u_shl_stage (
            .data   (src_p[k].data),
            .sel    (src_p[k].ctrl[SHW-1-k]),
            .rot    (src_p[k].rot),
            .result (shifted[k])
        );

        // Carry forward only the control bits later stages still have to act on.
        assign stage_d[k] = '{
            data: shifted[k],
            ctrl: src_p[k].ctrl & SHW'((1 << (SHW - 1 - k)) - 1),
            rot:  src_p[k].rot
        };
    end

    assign valid_in = {valid_q[SHW-2:0], in_valid};

    // Advance chain unrolled through a running term: adv[k] is out_ready or any
    // empty slot at or beyond stage k.
    always_comb begin
        logic tail;
        adv  = '0;
        tail = out_ready;
        for (int unsigned i = 0; i < SHW; i++) begin
            tail             = tail | ~valid_q[SHW-1-i];
            adv[SHW-1-i]     = tail;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int unsigned k = 0; k < SHW; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < SHW; k++) begin
                if (adv[k]) begin
                    valid_q[k] <= valid_in[k];
                    if (valid_in[k]) begin
                        stage_q[k] <= stage_d[k];
                    end
                end
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = valid_q[SHW-1];
    assign out_data  = stage_q[SHW-1].data;

endmodule

// File: tb/tb_barrel_shift_left_pipe.sv
// Self-checking bench for barrel_shift_left_pipe: directed cases plus a randomized
// scoreboard against an arithmetic shift/rotate model.
module tb_barrel_shift_left_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [3:0]  in_ctrl;
    logic        in_rot;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;

    int unsigned total;
    int unsigned bad;
    logic [15:0] exp_q [$];

    barrel_shift_left_pipe #(
        .WIDTH (16),
        .SHW   (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .in_rot    (in_rot),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] shl_model(input logic [15:0] d, input int unsigned c, input logic r);
        logic [31:0] dbl;
        if (r) begin
            dbl = {d, d} << c;
            return dbl[31:16];
        end
        return 16'((32'(d) << c) & 32'hFFFF);
    endfunction

    // One clock cycle: drive at negedge, sample settled outputs, scoreboard.
    task automatic step(input logic iv, input logic [15:0] d, input logic [3:0] c, input logic r,
                        input logic [15:0] exp, input logic ordy, output logic took);
        logic [15:0] e;
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = c;
        in_rot    = r;
        out_ready = ordy;
        #1;
        took = iv && in_ready;
        if (out_valid && exp_q.size() == 0) begin
            check("spurious", {31'd0, out_valid}, 32'd0);
        end else if (out_valid && out_ready) begin
            e = exp_q.pop_front();
            check("data", {16'd0, out_data}, {16'd0, e});
        end
        if (took) exp_q.push_back(exp);
    endtask

    task automatic idle(input logic ordy);
        logic t;
        step(1'b0, 16'h0, 4'h0, 1'b0, 16'h0, ordy, t);
    endtask

    task automatic send(input logic [15:0] d, input logic [3:0] c, input logic r, input logic [15:0] exp);
        logic t;
        t = 1'b0;
        for (int n = 0; n < 50 && !t; n++) step(1'b1, d, c, r, exp, 1'b1, t);
        if (!t) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && exp_q.size() != 0; n++) idle(1'b1);
        check("drain", exp_q.size(), 32'd0);
    endtask

    initial begin
        logic        t;
        logic        have;
        logic [15:0] rd;
        logic [3:0]  rc;
        logic        rr;
        int          n;
        int          acc;
        int          sent;
        logic [15:0] bd [6];
        logic [3:0]  bc [6];
        logic        br [6];

        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; in_ctrl = '0; in_rot = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {16'd0, out_data}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Single op latency
        send(16'h0001, 4'd15, 1'b0, 16'h8000);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            idle(1'b1);
            if (out_valid) begin n = i; break; end
        end
        check("latency", n, 32'd4);
        drain();

        // Logical vs rotate, pass-through
        send(16'h8001, 4'd1, 1'b0, 16'h0002);
        send(16'h8001, 4'd1, 1'b1, 16'h0003);
        send(16'hA5C3, 4'd4, 1'b1, 16'h5C3A);
        send(16'h1234, 4'd0, 1'b0, 16'h1234);
        send(16'h1234, 4'd0, 1'b1, 16'h1234);
        drain();

        // Back-to-back sweep of every shift amount
        rd = 16'hB00D;
        for (int c = 0; c < 16; c++) begin
            rr = c[0];
            step(1'b1, rd, 4'(c), rr, shl_model(rd, c, rr), 1'b1, t);
            check("sweep_accept", {31'd0, t}, 32'd1);
        end
        drain();

        // Backpressure: six operands offered with the output blocked
        for (int i = 0; i < 6; i++) begin
            bd[i] = 16'($urandom);
            bc[i] = 4'($urandom_range(0, 15));
            br[i] = 1'($urandom_range(0, 1));
        end
        acc = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            step(1'b1, bd[acc], bc[acc], br[acc], shl_model(bd[acc], bc[acc], br[acc]), 1'b0, t);
            if (out_valid) check("bp_hold", {16'd0, out_data}, {16'd0, exp_q[0]});
            if (t) acc++;
        end
        check("bp_accept", acc, 32'd4);
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        while (acc < 6) begin
            send(bd[acc], bc[acc], br[acc], shl_model(bd[acc], bc[acc], br[acc]));
            acc++;
        end
        drain();

        // Reset with three operands in flight
        for (int i = 0; i < 3; i++) begin
            rd = 16'($urandom);
            send(rd, 4'd3, 1'b1, shl_model(rd, 3, 1'b1));
        end
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) idle(1'b1);

        // Randomized traffic
        sent = 0;
        have = 1'b0;
        rd = '0; rc = '0; rr = 1'b0;
        for (int cyc = 0; cyc < 20000 && sent < 1000; cyc++) begin
            if (!have && $urandom_range(0, 9) < 7) begin
                have = 1'b1;
                rd = 16'($urandom);
                rc = 4'($urandom_range(0, 15));
                rr = 1'($urandom_range(0, 1));
            end
            step(have, rd, rc, rr, shl_model(rd, rc, rr), 1'($urandom_range(0, 3) != 0), t);
            if (t) begin
                have = 1'b0;
                sent++;
            end
        end
        check("random_sent", sent, 32'd1000);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/barrel_shift_left_pipe.md
Name: barrel_shift_left_pipe

Overview:
- Pipelined 16-bit left barrel shifter. It is the left-shift and rotate counterpart of the existing combinational logical right shifter.
- Uses four registered stages (shift by 8, 4, 2, 1) with a valid/ready handshake on input and output.
- Accepts one operand per cycle under no backpressure.
- Feeds the board-state packing path, which needs left-justified cell fields.

Parameters:
- WIDTH, 16, data width in bits.
- SHW, 4, shift-amount width; equals log2(WIDTH) and sets the number of stages.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous reset, active-low.
- in_valid  input  1  in_data, in_ctrl and in_rot are valid this cycle.
- in_ready  output  1  block accepts input this cycle.
- in_data  input  WIDTH  operand.
- in_ctrl  input  SHW  left shift amount, 0..15.
- in_rot  input  1  0 = logical left (zero fill), 1 = rotate left.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  WIDTH  shifted result.

Behaviour:
- Reset: rst_n sampled low at a rising clk edge clears every stage valid bit and every data register. After that edge: out_valid=0, out_data=16'h0000, in_ready=1.
- Reset mid-operation: all in-flight operands are discarded. Nothing is emitted afterwards.
- Stage k (k=0..3) registers four fields: valid, data, remaining ctrl bits, rot flag.
- Stage k shift amount: 2^(SHW-1-k), i.e. 8, 4, 2, 1.
- Stage k applies its shift iff its ctrl bit [SHW-1-k] is set; otherwise data passes unchanged.
- Logical shift: data << s, vacated LSBs filled with 0.
- Rotate: {data[WIDTH-1-s:0], data[WIDTH-1:WIDTH-s]}.
- Result is computed modulo WIDTH, with no overflow flag.
  - in_ctrl=0 returns in_data unchanged.
  - in_ctrl=15 logical keeps only in_data[0], placed at bit 15.
- Handshake:
  - A transfer occurs on a rising edge where valid && ready.
  - in_valid/data/ctrl/rot must be held stable while in_valid=1 and in_ready=0.
  - out_data must be held stable while out_valid=1 and out_ready=0.
- Advance rule (bubble-collapsing pipeline):
  - adv3 = ~v3 | out_ready.
  - adv(k) = ~v(k) | adv(k+1).
  - in_ready = adv0, which is combinational from out_ready through the stage valid bits.
  - A stage loads from its predecessor when its own adv is true. The loaded valid bit is the predecessor's valid.
- Latency: 4 cycles from an accepted input to out_valid, assuming no stall.
- Throughput: 1 operand per cycle while out_ready=1.
- Full: all four stages valid and out_ready=0 → in_ready=0, and nothing moves.
- Stall with bubbles: an empty stage keeps accepting input even while out_ready=0. The pipeline compresses until full.
- Empty: out_valid=0. out_data holds its last value; the bench must not check it.
- Simultaneous output pop and input push in the same cycle when full is allowed and loses no data.
- Ordering: outputs appear strictly in input order. No reordering and no duplication.

Decomposition:
- Shared package shifter_pkg holds:
  - WIDTH_DEFAULT=16 and SHW_DEFAULT=4.
  - The stage-shift constant table {8,4,2,1}.
  - A typedef for the stage payload struct {data, ctrl, rot}.
- One sub-module, shl_stage:
  - Combinational conditional shift/rotate by a fixed parameter S, driven by one select bit and the rot flag.
  - Instantiated 4 times, with pipeline registers in the parent.
  - Reuse mux2X1 inside shl_stage per bit.

Test Plan:
1. Reset, then single op: in_data=16'h0001, in_ctrl=15, in_rot=0 → out_valid exactly 4 cycles later, out_data=16'h8000.
2. Logical vs rotate: 16'h8001, ctrl=1, rot=0 → 16'h0002. Same operand with rot=1 → 16'h0003. Then 16'hA5C3, ctrl=4, rot=1 → 16'h5C3A.
3. Pass-through and full sweep: 16'h1234 with ctrl=0 → 16'h1234. Then ctrl=0..15 in back-to-back cycles with out_ready=1 → 16 results, one per cycle, in order, and in_ready never 0.
4. Backpressure:
   - Hold out_ready=0 while streaming 6 operands → in_ready drops after 4 are accepted; out_data is stable.
   - Release out_ready → the remaining operands complete in order with no loss or duplicates.
5. Reset mid-stream: drive rst_n low for 1 cycle with 3 operands in flight → out_valid=0 from the next cycle, and no stale outputs ever appear.
6. Random constrained: 1000 operands with random out_ready and in_valid → a scoreboard against the model ((rot ? rotl : shl)(data, ctrl)) shows zero mismatches.
